ntt_stage_seq: RTL
==================

// Module: ntt_stage_seq
// PURPOSE
//  Stage sequencer for the radix-2 NTT engine: on start, walks LOGN in-place Cooley-Tukey stages of N/2 butterflies each.
//  Issues read addresses, ping-pong bank select and twiddle-ROM address; drives bfu_en.
//  Emits write-back strobes/addresses delayed by RAM_LAT+BFU_LAT, and drains the pipeline between stages.
//  Sits between the host start/done handshake and the ntt2_pipeline + 4-bank RAM array.
// PARAMETERS
//  LOGN     8  log2 of transform length N (N=1<<LOGN); address width AW=LOGN-1 per bank half.
//  BFU_LAT  4  butterfly pipeline latency, bfu_en to xout/yout valid (cycles).
//  RAM_LAT  1  RAM/ROM read latency, address to data (cycles).
// PORTS
//  clk        in   1      single clock, rising edge.
//  reset      in   1      synchronous, active-high.
//  start      in   1      begin transform; sampled only in IDLE.
//  busy       out  1      high in ISSUE/DRAIN.
//  done       out  1      one-cycle pulse after final write-back.
//  stage      out  LOGN-bit  current stage index s (0..LOGN-1).
//  rd_en      out  1      read strobe to source bank.
//  rd_addr_x  out  LOGN   x operand address; rd_addr_y = rd_addr_x + (1<<s).
//  rd_addr_y  out  LOGN   y operand address.
//  rd_bank    out  1      source bank = s[0].
//  tw_addr    out  LOGN-1 twiddle ROM address, valid with rd_en.
//  bfu_en     out  1      rd_en delayed RAM_LAT (operands on RAM outputs).
//  wr_en      out  1      rd_en delayed RAM_LAT+BFU_LAT.
//  wr_addr_x  out  LOGN   rd_addr_x delayed RAM_LAT+BFU_LAT.
//  wr_addr_y  out  LOGN   rd_addr_y delayed RAM_LAT+BFU_LAT.
//  wr_bank    out  1      ~source bank, delayed with wr_en.
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; delay lines cleared. Reset mid-transform aborts: no further wr_en, no done.
//  FSM: IDLE -start-> ISSUE; ISSUE (N/2 cycles, k=0..N/2-1) -> DRAIN; DRAIN (D=RAM_LAT+BFU_LAT cycles) ->
//   ISSUE with s+1 if s<LOGN-1, else DONE; DONE (1 cycle, done=1) -> IDLE.
//  Addressing, stage s, butterfly k: h=1<<s, p=k&(h-1), g=k>>s; x=(g<<(s+1))|p; y=x+h; tw=p<<(LOGN-1-s).
//  Widths: all unsigned, no overflow by construction; k, p, g held in LOGN-1 bits.
//  Ping-pong: stage s reads bank s[0] and writes bank ~s[0]. The final result lands in bank LOGN[0].
//  DRAIN guarantees the last write of stage s precedes the first read of stage s+1; no read/write overlap on a bank.
//  Latency: start sampled at cycle 0 -> done at cycle LOGN*(N/2+D)+1; busy high cycles 1..LOGN*(N/2+D).
//  start while busy/DONE: ignored (no queueing). start held high in IDLE after done: new transform begins.
//  Delay lines shift every cycle regardless of state, so in-flight writes complete in DRAIN.
// CONFIGURATION
//  NTT_INVERSE_EN defined: adds input `inv` (1 bit), sampled with start and held for the transform.
//   If inv=1, tw_addr is tw | (1<<(LOGN-1)), indexing the inverse-twiddle upper ROM half; ROM depth N.
//   Also adds output `scale_en`, which is wr_en during the last stage, for the n^-1 multiply.
//  NTT_INVERSE_EN undefined: no inv/scale_en ports; ROM depth N/2; forward twiddles only.
// STRUCTURE
//  Shared define.v: `Addrwidth, `Addrwidth_rom, state encodings (IDLE/ISSUE/DRAIN/DONE) as localparam defines.
//  One sub-module: ntt_delay_line (param WIDTH, DEPTH; sync reset clears), instanced for the bfu_en delay and
//   the {wr_en,wr_bank,wr_addr_x,wr_addr_y} delay.
// TESTING (LOGN=3, BFU_LAT=4, RAM_LAT=1, D=5)
//  Reset then start pulse at cycle 0 -> busy 1..27, done=1 at cycle 28 only, rd_en at 1-4, 10-13, 19-22.
//  Stage 0 ISSUE -> (x,y)=(0,1),(2,3),(4,5),(6,7), tw=0; stage 1 -> (0,2),(1,3),(4,6),(5,7), tw=0,2,0,2.
//  Stage 2 -> (0,4),(1,5),(2,6),(3,7), tw=0,1,2,3; rd_bank=0,1,0; wr_bank=1,0,1.
//  wr_en/wr_addr equal rd_en/rd_addr shifted exactly 5 cycles; bfu_en equals rd_en shifted 1 cycle.
//  No wr_en in the first cycle of any ISSUE.
//  start pulsed at cycle 12 (busy) -> ignored, done still at 28; reset at cycle 15 -> all outputs 0 at 16,
//   no wr_en or done afterwards until a new start.
//  NTT_INVERSE_EN with inv=1 -> stage 2 tw=4,5,6,7; scale_en high cycles 24-27 only.

Source files
------------

// File: rtl/ntt_stage_seq_pkg.sv
// Shared types and helpers for the NTT stage sequencer.
// The sequencer states and the derived drain/counter sizes live here.
package ntt_stage_seq_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_t;

    // Cycles between the last read of a stage and the first read of the next.
    function automatic int unsigned drain_cycles(int unsigned ram_lat, int unsigned bfu_lat);
        return ram_lat + bfu_lat;
    endfunction

    function automatic int unsigned cnt_width(int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ntt_stage_seq_if.sv
// Host/RAM-side signal bundle of the NTT stage sequencer.
// NTT_INVERSE_EN adds inv/scale_en and widens tw_addr to index the inverse ROM half.
interface ntt_stage_seq_if #(
    parameter int unsigned LOGN = 8
);
`ifdef NTT_INVERSE_EN
    localparam int unsigned TW_W = LOGN;
`else
    localparam int unsigned TW_W = LOGN - 1;
`endif

    logic            start;
    logic            busy;
    logic            done;
    logic [LOGN-1:0] stage;
    logic            rd_en;
    logic [LOGN-1:0] rd_addr_x;
    logic [LOGN-1:0] rd_addr_y;
    logic            rd_bank;
    logic [TW_W-1:0] tw_addr;
    logic            bfu_en;
    logic            wr_en;
    logic [LOGN-1:0] wr_addr_x;
    logic [LOGN-1:0] wr_addr_y;
    logic            wr_bank;
`ifdef NTT_INVERSE_EN
    logic            inv;
    logic            scale_en;
`endif

    modport master (
`ifdef NTT_INVERSE_EN
        input  inv,
        output scale_en,
`endif
        input  start,
        output busy, done, stage, rd_en, rd_addr_x, rd_addr_y, rd_bank, tw_addr,
        output bfu_en, wr_en, wr_addr_x, wr_addr_y, wr_bank
    );

    modport slave (
`ifdef NTT_INVERSE_EN
        output inv,
        input  scale_en,
`endif
        output start,
        input  busy, done, stage, rd_en, rd_addr_x, rd_addr_y, rd_bank, tw_addr,
        input  bfu_en, wr_en, wr_addr_x, wr_addr_y, wr_bank
    );

endinterface

// File: rtl/ntt_stage_seq_delay_line.sv
// Fixed-depth shift register, cleared by synchronous reset.
module ntt_stage_seq_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_stage_seq.sv
// Radix-2 NTT stage sequencer: walks LOGN Cooley-Tukey stages, issuing reads and delayed writes.
// Optional feature macro: NTT_INVERSE_EN (inverse twiddle half and scale_en strobe).
module ntt_stage_seq
    import ntt_stage_seq_pkg::*;
#(
    parameter int unsigned LOGN    = 8,
    parameter int unsigned BFU_LAT = 4,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    ntt_stage_seq_if.master bus
);

    localparam int unsigned AW = LOGN - 1;
    localparam int unsigned D  = drain_cycles(RAM_LAT, BFU_LAT);
    localparam int unsigned DW = cnt_width(D);
`ifdef NTT_INVERSE_EN
    localparam int unsigned WW = 2 * LOGN + 3;
`else
    localparam int unsigned WW = 2 * LOGN + 2;
`endif
    localparam logic [AW-1:0]   K_MAX      = '1;
    localparam logic [DW-1:0]   DRAIN_LAST = DW'(D - 1);
    localparam logic [LOGN-1:0] S_LAST     = LOGN'(LOGN - 1);

    state_t          state_q, state_d;
    logic [LOGN-1:0] s_q, s_d;
    logic [AW-1:0]   k_q, k_d;
    logic [DW-1:0]   cnt_q, cnt_d;
`ifdef NTT_INVERSE_EN
    logic            inv_q, inv_d;
`endif

    logic            issue;
    logic            last_stage;
    logic [AW-1:0]   mask, p, g, tw;
    logic [LOGN-1:0] x, y, rd_x, rd_y;
    logic [WW-1:0]   wr_din, wr_dout;
    logic            bfu_dout;

    assign issue      = (state_q == StIssue);
    assign last_stage = (s_q == S_LAST);

    // Butterfly addressing: p is the offset within a group, g the group index.
    always_comb begin
        mask = ~({AW{1'b1}} << s_q);
        p    = k_q & mask;
        g    = k_q >> s_q;
        x    = ({1'b0, g} << (s_q + LOGN'(1))) | {1'b0, p};
        y    = x + (LOGN'(1) << s_q);
        tw   = p << (LOGN'(AW) - s_q);
    end

    assign rd_x = issue ? x : '0;
    assign rd_y = issue ? y : '0;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
`ifdef NTT_INVERSE_EN
        inv_d   = inv_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StIssue;
                    s_d     = '0;
                    k_d     = '0;
`ifdef NTT_INVERSE_EN
                    inv_d   = bus.inv;
`endif
                end
            end
            StIssue: begin
                k_d = k_q + AW'(1);
                if (k_q == K_MAX) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end
            end
            StDrain: begin
                cnt_d = cnt_q + DW'(1);
                if (cnt_q == DRAIN_LAST) begin
                    if (last_stage) begin
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                        s_d     = s_q + LOGN'(1);
                        k_d     = '0;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                s_d     = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            s_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
`ifdef NTT_INVERSE_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
`ifdef NTT_INVERSE_EN
            inv_q   <= inv_d;
`endif
        end
    end

    // Write side carries addresses already zeroed outside ISSUE, so idle writes stay all-zero.
`ifdef NTT_INVERSE_EN
    assign wr_din = {issue & last_stage, issue & ~s_q[0], rd_x, rd_y, issue};
`else
    assign wr_din = {issue & ~s_q[0], rd_x, rd_y, issue};
`endif

    ntt_stage_seq_delay_line #(
        .WIDTH (1),
        .DEPTH (RAM_LAT)
    ) u_bfu_dly (
        .clk   (clk),
        .reset (reset),
        .din   (issue),
        .dout  (bfu_dout)
    );

    ntt_stage_seq_delay_line #(
        .WIDTH (WW),
        .DEPTH (D)
    ) u_wr_dly (
        .clk   (clk),
        .reset (reset),
        .din   (wr_din),
        .dout  (wr_dout)
    );

    assign bus.busy      = issue || (state_q == StDrain);
    assign bus.done      = (state_q == StDone);
    assign bus.stage     = s_q;
    assign bus.rd_en     = issue;
    assign bus.rd_addr_x = rd_x;
    assign bus.rd_addr_y = rd_y;
    assign bus.rd_bank   = issue & s_q[0];
`ifdef NTT_INVERSE_EN
    assign bus.tw_addr   = issue ? {inv_q, tw} : '0;
    assign bus.scale_en  = wr_dout[WW-1];
`else
    assign bus.tw_addr   = issue ? tw : '0;
`endif
    assign bus.bfu_en    = bfu_dout;
    assign bus.wr_en     = wr_dout[0];
    assign bus.wr_addr_y = wr_dout[LOGN:1];
    assign bus.wr_addr_x = wr_dout[2*LOGN:LOGN+1];
    assign bus.wr_bank   = wr_dout[2*LOGN+1];

endmodule
